// File: rtl/fetch_redirect_unit_pkg.sv
// fetch_redirect_unit_pkg: opcode/funct encodings, special instruction words and FSM states for the ID-side redirect unit.
package fetch_redirect_unit_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_SB = 6'h28;
  localparam logic [5:0] OP_SH = 6'h29;
  localparam logic [5:0] OP_SW = 6'h2B;
  localparam logic [5:0] FN_JR = 6'h08;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  typedef enum logic {RUN, HALT} state_e;
  function automatic logic is_store(input logic [5:0] op);
    return op == OP_SB || op == OP_SH || op == OP_SW;
  endfunction
endpackage

// File: rtl/fetch_redirect_unit_if.sv
// fetch_redirect_unit_if: fetch-stage <-> redirect-unit bus (fetched word in, PC control out).
interface fetch_redirect_unit_if;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic branch_taken;
  logic jump_taken;
  logic [31:0] branch_offset;
  logic [31:0] new_addr;
  logic stall;
  modport master (output if_pc, if_instr, input branch_taken, jump_taken, branch_offset, new_addr, stall);
  modport slave (input if_pc, if_instr, output branch_taken, jump_taken, branch_offset, new_addr, stall);
endinterface

// File: rtl/fetch_redirect_unit_hazard_detect.sv
// fetch_redirect_unit_hazard_detect: combinational load-use and branch-operand hazard detection.
module fetch_redirect_unit_hazard_detect (
  input  logic       use_rs,
  input  logic       use_rt,
  input  logic       cmp_rs,
  input  logic       cmp_rt,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dest,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_dest,
  output logic       hazard
);
  logic ex_rs, ex_rt, mem_rs, mem_rt, h_load, h_br_ex, h_br_mem;
  always_comb begin
    ex_rs = ex_dest != '0 && ex_dest == rs;
    ex_rt = ex_dest != '0 && ex_dest == rt;
    mem_rs = mem_dest != '0 && mem_dest == rs;
    mem_rt = mem_dest != '0 && mem_dest == rt;
    h_load = ex_mem_read & (use_rs & ex_rs | use_rt & ex_rt);
    h_br_ex = ex_reg_write & (cmp_rs & ex_rs | cmp_rt & ex_rt);
    h_br_mem = mem_mem_read & (cmp_rs & mem_rs | cmp_rt & mem_rt);
    hazard = h_load | h_br_ex | h_br_mem;
  end
endmodule

// File: rtl/fetch_redirect_unit.sv
// fetch_redirect_unit: IF/ID latch, control-flow decode, redirect/stall generation and HALT freeze.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  fetch_redirect_unit_if.slave        fif,
  input  logic [31:0]                 rs_data,
  input  logic [31:0]                 rt_data,
  input  logic                        ex_reg_write,
  input  logic                        ex_mem_read,
  input  logic [4:0]                  ex_dest,
  input  logic                        mem_mem_read,
  input  logic [4:0]                  mem_dest,
  output logic [31:0]                 id_pc,
  output logic [31:0]                 id_instr,
  output logic [4:0]                  id_rs,
  output logic [4:0]                  id_rt,
  output logic                        id_issue,
  output logic                        halted
);
  logic [31:0] id_pc_q, id_pc_d, id_instr_q, id_instr_d, new_addr;
  logic id_valid_q, id_valid_d;
  state_e state_q, state_d;
  logic [5:0] op, fn;
  logic is_beq, is_bne, is_j, is_jal, is_jr, use_rs, use_rt, hazard, halt, stall, act, bt, jt;
  fetch_redirect_unit_hazard_detect u_hazard (
    .use_rs(use_rs), .use_rt(use_rt), .cmp_rs(is_beq | is_bne | is_jr), .cmp_rt(is_beq | is_bne),
    .rs(id_instr_q[25:21]), .rt(id_instr_q[20:16]),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .mem_mem_read(mem_mem_read), .mem_dest(mem_dest), .hazard(hazard)
  );
  always_comb begin
    op = id_instr_q[31:26];
    fn = id_instr_q[5:0];
    is_beq = op == OP_BEQ;
    is_bne = op == OP_BNE;
    is_j = op == OP_J;
    is_jal = op == OP_JAL;
    is_jr = op == OP_RTYPE && fn == FN_JR;
    use_rs = !(is_j | is_jal);
    use_rt = (op == OP_RTYPE && !is_jr) | is_beq | is_bne | is_store(op);
    halt = state_q == HALT;
    stall = id_valid_q & hazard | halt;
    act = id_valid_q & ~stall;
    bt = act & (is_beq & rs_data == rt_data | is_bne & rs_data != rt_data);
    jt = act & (is_j | is_jal | is_jr);
    new_addr = is_jr ? rs_data : (is_j | is_jal) ? {fif.if_pc[31:28], id_instr_q[25:0], 2'b00} : '0;
    // a redirect keeps the PC moving but squashes the wrong-path word already fetched
    id_pc_d = stall ? id_pc_q : fif.if_pc;
    id_instr_d = stall ? id_instr_q : (bt | jt) ? NOP_WORD : fif.if_instr;
    id_valid_d = stall ? id_valid_q : ~(bt | jt);
    state_d = act && id_instr_q == HALT_WORD ? HALT : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      id_pc_q <= '0;
      id_instr_q <= NOP_WORD;
      id_valid_q <= 1'b0;
      state_q <= RUN;
    end else begin
      id_pc_q <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
      state_q <= state_d;
    end
  end
  assign fif.branch_taken = bt;
  assign fif.jump_taken = jt;
  assign fif.branch_offset = {{16{id_instr_q[15]}}, id_instr_q[15:0]};
  assign fif.new_addr = new_addr;
  assign fif.stall = stall;
  assign id_pc = id_pc_q;
  assign id_instr = id_instr_q;
  assign id_rs = id_instr_q[25:21];
  assign id_rt = id_instr_q[20:16];
  assign id_issue = act;
  assign halted = state_q == HALT;
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// tb_fetch_redirect_unit: directed vectors for the IF/ID latch, redirects, hazards and HALT.
module tb_fetch_redirect_unit;
  localparam logic [31:0] ADD = 32'h0041_1820;
  localparam logic [31:0] BEQ = 32'h1085_0003;
  localparam logic [31:0] JMP = 32'h0800_0040;
  localparam logic [31:0] HLT = 32'hFFFF_FFFF;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] rs_data = '0, rt_data = '0, id_pc, id_instr;
  logic ex_reg_write = 1'b0, ex_mem_read = 1'b0, mem_mem_read = 1'b0;
  logic [4:0] ex_dest = '0, mem_dest = '0, id_rs, id_rt;
  logic id_issue, halted;
  int n_cmp = 0, n_bad = 0;
  fetch_redirect_unit_if fif();
  fetch_redirect_unit dut (
    .clk(clk), .rst(rst), .fif(fif), .rs_data(rs_data), .rt_data(rt_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .mem_mem_read(mem_mem_read), .mem_dest(mem_dest), .id_pc(id_pc), .id_instr(id_instr),
    .id_rs(id_rs), .id_rt(id_rt), .id_issue(id_issue), .halted(halted)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
    fif.if_pc = pc;
    fif.if_instr = ins;
    #1;
  endtask
  initial begin
    fetch(32'h0, ADD);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_stall", fif.stall, 0);
    chk("rst_bt", fif.branch_taken, 0);
    chk("rst_jt", fif.jump_taken, 0);
    chk("rst_issue", id_issue, 0);
    chk("rst_halted", halted, 0);
    chk("rst_new_addr", fif.new_addr, 0);
    chk("rst_offset", fif.branch_offset, 0);
    chk("rst_instr", id_instr, 0);
    for (int i = 0; i < 3; i++) begin
      fetch(32'(i * 4), ADD);
      tick();
      fetch(32'h100, ADD);
      chk("seq_pc", id_pc, 32'(i * 4));
      chk("seq_issue", id_issue, 1);
      chk("seq_stall", fif.stall, 0);
      chk("seq_redir", {fif.branch_taken, fif.jump_taken}, 0);
    end
    fetch(32'h10, BEQ);
    tick();
    rs_data = 5;
    rt_data = 5;
    fetch(32'h14, ADD);
    chk("beq_bt", fif.branch_taken, 1);
    chk("beq_jt", fif.jump_taken, 0);
    chk("beq_offset", fif.branch_offset, 3);
    tick();
    chk("beq_squash_instr", id_instr, 0);
    chk("beq_squash_pc", id_pc, 32'h14);
    chk("beq_squash_issue", id_issue, 0);
    fetch(32'h10, BEQ);
    tick();
    rt_data = 6;
    fetch(32'h14, ADD);
    chk("beq_nt_bt", fif.branch_taken, 0);
    chk("beq_nt_issue", id_issue, 1);
    tick();
    chk("beq_nt_next", id_instr, ADD);
    fetch(32'h20, JMP);
    tick();
    fetch(32'h2000_0004, ADD);
    chk("j_jt", fif.jump_taken, 1);
    chk("j_bt", fif.branch_taken, 0);
    chk("j_new_addr", fif.new_addr, 32'h2000_0100);
    tick();
    chk("j_squash_issue", id_issue, 0);
    chk("j_squash_instr", id_instr, 0);
    fetch(32'h30, ADD);
    tick();
    ex_mem_read = 1'b1;
    ex_dest = 2;
    fetch(32'h34, BEQ);
    chk("lu_stall", fif.stall, 1);
    chk("lu_issue", id_issue, 0);
    tick();
    ex_mem_read = 1'b0;
    #1;
    chk("lu_hold_pc", id_pc, 32'h30);
    chk("lu_clear", fif.stall, 0);
    chk("lu_issue2", id_issue, 1);
    ex_mem_read = 1'b1;
    ex_dest = 0;
    #1;
    chk("lu_r0", fif.stall, 0);
    ex_mem_read = 1'b0;
    fetch(32'h40, BEQ);
    tick();
    rs_data = 7;
    rt_data = 7;
    ex_reg_write = 1'b1;
    ex_dest = 5;
    fetch(32'h44, ADD);
    chk("br_ex_stall", fif.stall, 1);
    chk("br_ex_no_bt", fif.branch_taken, 0);
    tick();
    ex_reg_write = 1'b0;
    ex_dest = 0;
    mem_mem_read = 1'b1;
    mem_dest = 5;
    #1;
    chk("br_mem_hold", id_pc, 32'h40);
    chk("br_mem_stall", fif.stall, 1);
    tick();
    mem_mem_read = 1'b0;
    mem_dest = 0;
    #1;
    chk("br_res_stall", fif.stall, 0);
    chk("br_res_bt", fif.branch_taken, 1);
    tick();
    fetch(32'h50, HLT);
    tick();
    fetch(32'h54, ADD);
    chk("halt_issue", id_issue, 1);
    chk("halt_pre", halted, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("halted", halted, 1);
      chk("halt_stall", fif.stall, 1);
      chk("halt_issue_off", id_issue, 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst2_halted", halted, 0);
    chk("rst2_instr", id_instr, 0);
    chk("rst2_stall", fif.stall, 0);
    chk("rst2_issue", id_issue, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- ID-side partner of the fetch stage. It holds the IF/ID pipeline latch and decodes the latched instruction for control flow.
- It drives the fetch stage's control inputs: branch_taken, jump_taken, branch_offset, new_addr and stall.
- It detects load-use and branch-operand hazards, squashes the wrong-path fetch on a redirect, and freezes on HALT.
- It sits between the fetch stage and the decode/register-read logic.

Parameters:
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops the pipeline.
- NOP_WORD, 32'h0000_0000, encoding loaded into the latch on reset or flush.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_pc  in  32  PC currently held by the fetch stage (address of if_instr)
- if_instr  in  32  instruction fetched at if_pc
- rs_data  in  32  forwarded value of register id_rs
- rt_data  in  32  forwarded value of register id_rt
- ex_reg_write  in  1  EX-stage instruction writes a register
- ex_mem_read  in  1  EX-stage instruction is a load
- ex_dest  in  5  EX-stage destination register
- mem_mem_read  in  1  MEM-stage instruction is a load
- mem_dest  in  5  MEM-stage destination register
- id_pc  out  32  latched PC of the ID instruction
- id_instr  out  32  latched ID instruction
- id_rs  out  5  id_instr[25:21], register-file read address
- id_rt  out  5  id_instr[20:16], register-file read address
- id_issue  out  1  ID instruction is valid and advances to EX this cycle
- branch_taken  out  1  to fetch: next PC = if_pc + (branch_offset<<2)
- jump_taken  out  1  to fetch: next PC = new_addr
- branch_offset  out  32  sign-extended id_instr[15:0]
- new_addr  out  32  absolute jump target
- stall  out  1  to fetch: hold PC; also holds the IF/ID latch
- halted  out  1  HALT state reached

Behaviour:
- Latch registers: id_pc, id_instr, id_valid.
  - Reset: 0 / NOP_WORD / 0.
  - Each posedge, priority order:
    - rst: load reset values.
    - HALT state: hold.
    - stall: hold.
    - redirect (branch_taken|jump_taken): load id_pc=if_pc, id_instr=NOP_WORD, id_valid=0. This squashes the wrong-path fetch; there is no delay slot.
    - otherwise: load if_pc, if_instr, and id_valid=1.
- Decode classes (opcode = id_instr[31:26], funct = [5:0]):
  - BEQ 6'h04, BNE 6'h05, J 6'h02, JAL 6'h03.
  - JR: opcode 0 with funct 6'h08.
  - Register uses: rs for BEQ, BNE, JR and all others; rt for R-type, BEQ, BNE and stores. J and JAL use neither.
- Hazard terms (register $0 never matches):
  - h_load = ex_mem_read, ex_dest nonzero, and ex_dest equals a used rs/rt.
  - h_br_ex = instruction is BEQ/BNE/JR, ex_reg_write, ex_dest nonzero, and ex_dest equals a compared register.
  - h_br_mem = instruction is BEQ/BNE/JR, mem_mem_read, and mem_dest nonzero matching a compared register.
  - stall = id_valid & (h_load | h_br_ex | h_br_mem) | state==HALT. All combinational, same cycle.
- Redirect (combinational, only when id_valid and not stall):
  - branch_taken = (BEQ & rs_data==rt_data) | (BNE & rs_data!=rt_data).
  - jump_taken = J | JAL | JR.
  - new_addr = {if_pc[31:28], id_instr[25:0], 2'b00} for J/JAL; rs_data for JR; 0 otherwise.
  - branch_taken and jump_taken are never both 1.
- id_issue = id_valid & ~stall. On stall, downstream inserts a bubble.
- State machine:
  - States: RUN, HALT. Reset → RUN.
  - RUN → HALT at the posedge where id_valid, id_instr==HALT_WORD and ~stall. That HALT word issues once.
  - In HALT: stall=1, id_issue=0, branch_taken=jump_taken=0, halted=1. It stays there until rst.
- Reset outputs: stall=0, branch_taken=0, jump_taken=0, id_issue=0, halted=0, new_addr=0, branch_offset=0.
- Reset mid-stall or mid-HALT: the next cycle is clean RUN with an empty latch.
- A redirect and a hazard in the same cycle: the hazard wins. The redirect is re-evaluated when the stall clears.
- A back-to-back branch after a taken branch cannot occur, because the slot is squashed.

Decomposition:
- Shared constants header (with WORD): opcode/funct localparams (OP_BEQ, OP_BNE, OP_J, OP_JAL, FN_JR), NOP_WORD, HALT_WORD.
- One sub-module, hazard_detect: purely combinational; takes decoded uses plus the EX/MEM fields; outputs the stall term.
- The latch, decode, redirect and FSM stay in the top module.

Test Plan:
- Reset, then feed sequential if_pc 0,4,8 with ADD words → id_issue=1 each cycle one cycle later, and stall, branch_taken and jump_taken stay 0.
- ID=BEQ offset 16'h0003 at 0x10, if_pc=0x14, rs_data=rt_data=5 → branch_taken=1, branch_offset=3; next cycle id_instr=NOP, id_issue=0. With rt_data=6 → no redirect.
- ID=J target 26'h0000040, if_pc=0x2000_0004 → jump_taken=1, new_addr=0x2000_0100; next cycle a squashed bubble.
- ID=ADD $3,$2,$1 with ex_mem_read=1, ex_dest=2 → stall=1 for one cycle and the latch holds. With ex_dest=0 → no stall.
- ID=BEQ $4,$5 with ex_reg_write and ex_dest=5 → stall 1 cycle. Then with mem_mem_read and mem_dest=5 → stall 1 more, then resolves.
- ID=HALT_WORD → issues once, then halted=1 and stall=1 indefinitely; assert rst → halted=0 and the latch empties.
